// File: rtl/text_pkg.sv
// Shared types and constants for the character screen buffer.
// Holds the FSM state type, the default screen geometry and the clear code.
// Also provides the cell-address width helper and the write-request bundle.
package text_pkg;

   localparam int         TXT_COLS     = 106;    // 640 px / 6 px per cell
   localparam int         TXT_ROWS     = 60;     // 480 lines / 8 lines per cell
   localparam logic [7:0] TXT_CLR_CODE = 8'h20;  // space: no glyph, renders dark

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_t;

   typedef struct packed {
      logic [7:0] x;
      logic [7:0] y;
      logic [7:0] code;
   } req_t;

   // Address width needed to index every cell of a cols x rows screen.
   function automatic int cell_aw(input int cols, input int rows);
      return $clog2(cols * rows);
   endfunction

endpackage

// File: rtl/text_buf_ram.sv
// Simple dual-port character RAM: one write port, one registered read port.
// Latency: read data valid one cycle after the read address is presented.
// No backpressure; read-during-write to one address returns the old data.
module text_buf_ram #(
   parameter int DEPTH = 6360,
   parameter int AW    = 13,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata_q
);

   logic [DW-1:0] mem [DEPTH];

   // Write port and registered read; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata_q <= mem[raddr];
   end

endmodule

// File: rtl/text_screen_ctrl.sv
// Character screen buffer owner: clear sequencer, 2-way write arbiter, overlay pixel pipe.
// Latency: pix_out is 2 cycles after char_x/char_y; writes are readable the cycle after handshake.
// Backpressure: both write readys are low during a clear sweep; otherwise round-robin grant.
module text_screen_ctrl
   import text_pkg::*;
#(
   parameter int         COLS     = TXT_COLS,
   parameter int         ROWS     = TXT_ROWS,
   parameter logic [7:0] CLR_CODE = TXT_CLR_CODE
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         blank,
   input  logic [7:0]   char_x,
   input  logic [7:0]   char_y,
   input  logic [255:0] ascii_char,
   input  logic         wr0_valid,
   output logic         wr0_ready,
   input  logic [7:0]   wr0_x,
   input  logic [7:0]   wr0_y,
   input  logic [7:0]   wr0_code,
   input  logic         wr1_valid,
   output logic         wr1_ready,
   input  logic [7:0]   wr1_x,
   input  logic [7:0]   wr1_y,
   input  logic [7:0]   wr1_code,
   input  logic         clear_req,
   output logic         clear_busy,
   output logic         pix_out
);

   localparam int            CELLS     = COLS * ROWS;
   localparam int            AW        = cell_aw(COLS, ROWS);
   localparam logic [7:0]    COLS_B    = 8'(COLS);
   localparam logic [7:0]    ROWS_B    = 8'(ROWS);
   localparam logic [AW-1:0] LAST_ADDR = AW'(CELLS - 1);

   // Linear cell address; only meaningful when (x, y) is on screen.
   function automatic logic [AW-1:0] addr_of(input logic [7:0] x, input logic [7:0] y);
      return AW'(y) * AW'(COLS) + AW'(x);
   endfunction

   function automatic logic on_screen(input logic [7:0] x, input logic [7:0] y);
      return (x < COLS_B) && (y < ROWS_B);
   endfunction

   state_t        state_q, state_d;
   logic [AW-1:0] clr_addr_q, clr_addr_d;
   logic          last_grant_q, last_grant_d;
   logic          grant0, grant1;
   req_t          req;

   logic          ram_we;
   logic [AW-1:0] ram_waddr;
   logic [7:0]    ram_wdata;
   logic [AW-1:0] ram_raddr;
   logic [7:0]    code_q;

   logic          rd_ok_d, rd_ok_q;
   logic          pix_q;

   // Control state: clear sweep position, FSM state and round-robin history.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= CLEAR;
         clr_addr_q   <= '0;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         clr_addr_q   <= clr_addr_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Next state, arbitration and the single RAM write port mux.
   always_comb begin
      state_d      = state_q;
      clr_addr_d   = clr_addr_q;
      last_grant_d = last_grant_q;
      grant0       = 1'b0;
      grant1       = 1'b0;
      req          = '{x: wr0_x, y: wr0_y, code: wr0_code};
      ram_we       = 1'b0;
      ram_waddr    = '0;
      ram_wdata    = CLR_CODE;

      unique case (state_q)
         CLEAR: begin
            // The sweep owns the write port; clear_req here is ignored.
            ram_we     = 1'b1;
            ram_waddr  = clr_addr_q;
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == LAST_ADDR) begin
               state_d    = IDLE;
               clr_addr_d = '0;
            end
         end
         IDLE: begin
            // On a tie, favour whichever requester did not win last time.
            grant0 = wr0_valid && (!wr1_valid || last_grant_q);
            grant1 = wr1_valid && !grant0;
            if (grant0) begin
               req          = '{x: wr0_x, y: wr0_y, code: wr0_code};
               last_grant_d = 1'b0;
            end else if (grant1) begin
               req          = '{x: wr1_x, y: wr1_y, code: wr1_code};
               last_grant_d = 1'b1;
            end
            // Off-screen writes still handshake but never touch the RAM.
            if ((grant0 || grant1) && on_screen(req.x, req.y)) begin
               ram_we    = 1'b1;
               ram_waddr = addr_of(req.x, req.y);
               ram_wdata = req.code;
            end
            // A same-cycle transfer lands first and is then swept over.
            if (clear_req) begin
               state_d    = CLEAR;
               clr_addr_d = '0;
            end
         end
         default: begin
            state_d    = CLEAR;
            clr_addr_d = '0;
         end
      endcase
   end

   assign wr0_ready  = grant0;
   assign wr1_ready  = grant1;
   assign clear_busy = (state_q == CLEAR);

   // Off-screen reads are steered to cell 0 and masked by rd_ok.
   assign ram_raddr = on_screen(char_x, char_y) ? addr_of(char_x, char_y) : '0;
   assign rd_ok_d   = !blank && on_screen(char_x, char_y);

   text_buf_ram #(
      .DEPTH (CELLS),
      .AW    (AW),
      .DW    (8)
   ) u_ram (
      .clk     (clk),
      .we      (ram_we),
      .waddr   (ram_waddr),
      .wdata   (ram_wdata),
      .raddr   (ram_raddr),
      .rdata_q (code_q)
   );

   // Display pipe: qualify the read, then pick the glyph bit once code_q lines up with ascii_char.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ok_q <= 1'b0;
         pix_q   <= 1'b0;
      end else begin
         rd_ok_q <= rd_ok_d;
         pix_q   <= rd_ok_q & ascii_char[code_q];
      end
   end

   assign pix_out = pix_q;

endmodule

// File: tb/tb_text_screen_ctrl.sv
// Randomized bench for text_screen_ctrl with a cell-array reference model.
// Expected pixels and handshake/busy values are queued per cycle and checked by a monitor.
// Inputs change on the falling edge; the monitor samples 4 ns after it.
`timescale 1ns/1ps
module tb_text_screen_ctrl;

   localparam int COLS  = 106;
   localparam int ROWS  = 60;
   localparam int CELLS = COLS * ROWS;

   logic         clk = 1'b0;
   logic         reset;
   logic         blank;
   logic [7:0]   char_x, char_y;
   logic [255:0] ascii_char;
   logic         wr0_valid, wr0_ready;
   logic [7:0]   wr0_x, wr0_y, wr0_code;
   logic         wr1_valid, wr1_ready;
   logic [7:0]   wr1_x, wr1_y, wr1_code;
   logic         clear_req, clear_busy, pix_out;

   text_screen_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .blank      (blank),
      .char_x     (char_x),
      .char_y     (char_y),
      .ascii_char (ascii_char),
      .wr0_valid  (wr0_valid),
      .wr0_ready  (wr0_ready),
      .wr0_x      (wr0_x),
      .wr0_y      (wr0_y),
      .wr0_code   (wr0_code),
      .wr1_valid  (wr1_valid),
      .wr1_ready  (wr1_ready),
      .wr1_x      (wr1_x),
      .wr1_y      (wr1_y),
      .wr1_code   (wr1_code),
      .clear_req  (clear_req),
      .clear_busy (clear_busy),
      .pix_out    (pix_out)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: screen contents plus a "has been written" mask.
   bit [7:0] m_mem   [CELLS];
   bit       m_known [CELLS];
   bit       m_busy;
   int       m_left;
   bit       m_last;

   // Read issued in the previous step, resolved once its glyph vector is known.
   bit       p_vld = 1'b0;
   bit       p_ok, p_known;
   bit [7:0] p_code;

   typedef struct { int due; bit chk; bit exp; } pix_exp_t;
   typedef struct { bit r0; bit r1; bit busy; } ctl_exp_t;
   pix_exp_t pq [$];
   ctl_exp_t cq [$];
   pix_exp_t pe, pe_m;
   ctl_exp_t ce, ce_m;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h cyc=%0d", nm, act, exp, cyc);
      end
   endtask

   function automatic void model_reset();
      m_busy = 1'b1;
      m_left = CELLS;
      m_last = 1'b1;
   endfunction

   function automatic void model_write(input bit [7:0] x, input bit [7:0] y, input bit [7:0] c);
      if (x < COLS && y < ROWS) begin
         m_mem[y * COLS + x]   = c;
         m_known[y * COLS + x] = 1'b1;
      end
   endfunction

   // One clock of stimulus; g0 reports whether the model expects wr0 to transfer.
   task automatic step(input bit bl, input bit [7:0] cx, input bit [7:0] cy,
                       input bit v0, input bit [7:0] x0, input bit [7:0] y0, input bit [7:0] c0,
                       input bit v1, input bit [7:0] x1, input bit [7:0] y1, input bit [7:0] c1,
                       input bit clr, input bit rst, output bit g0);
      logic [255:0] g;
      bit r0, r1, ok;
      int idx;
      @(negedge clk);
      g = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      g[65] = 1'b1;   // 'A' has lit pixels
      g[32] = 1'b0;   // space is dark
      blank = bl; char_x = cx; char_y = cy; ascii_char = g;
      wr0_valid = v0; wr0_x = x0; wr0_y = y0; wr0_code = c0;
      wr1_valid = v1; wr1_x = x1; wr1_y = y1; wr1_code = c1;
      clear_req = clr;
      if (rst) begin
         #1 reset = 1'b1;
         #1;
         chk("async_rst_rdy0", 32'(wr0_ready), 32'd0);
         chk("async_rst_rdy1", 32'(wr1_ready), 32'd0);
         chk("async_rst_busy", 32'(clear_busy), 32'd1);
         reset = 1'b0;
         model_reset();
      end
      #1;
      pe.due = cyc + 1;
      pe.chk = p_vld && (!p_ok || p_known);
      pe.exp = p_ok && g[p_code];
      pq.push_back(pe);
      if (m_busy) begin
         r0 = 1'b0;
         r1 = 1'b0;
      end else begin
         r0 = v0 && (!v1 || m_last);
         r1 = v1 && !r0;
      end
      ce.r0 = r0; ce.r1 = r1; ce.busy = m_busy;
      cq.push_back(ce);
      // Read sees the contents before this edge's write.
      ok      = !bl && cx < COLS && cy < ROWS;
      idx     = ok ? cy * COLS + cx : 0;
      p_vld   = 1'b1;
      p_ok    = ok;
      p_known = m_known[idx];
      p_code  = m_mem[idx];
      if (m_busy) begin
         m_mem[CELLS - m_left]   = 8'h20;
         m_known[CELLS - m_left] = 1'b1;
         m_left--;
         if (m_left == 0) m_busy = 1'b0;
      end else begin
         if (r0) begin model_write(x0, y0, c0); m_last = 1'b0; end
         if (r1) begin model_write(x1, y1, c1); m_last = 1'b1; end
         if (clr) begin m_busy = 1'b1; m_left = CELLS; end
      end
      g0 = r0;
   endtask

   task automatic rd(input bit bl, input bit [7:0] cx, input bit [7:0] cy);
      bit d;
      step(bl, cx, cy, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, d);
   endtask

   task automatic rnd_step(input bit wr_en, input bit force_blank);
      bit d;
      step(force_blank || ($urandom_range(0, 7) == 0),
           8'($urandom_range(0, 111)), 8'($urandom_range(0, 63)),
           wr_en && $urandom_range(0, 1) == 1,
           8'($urandom_range(0, 107)), 8'($urandom_range(0, 61)), 8'($urandom),
           wr_en && $urandom_range(0, 1) == 1,
           8'($urandom_range(0, 107)), 8'($urandom_range(0, 61)), 8'($urandom),
           1'b0, 1'b0, d);
   endtask

   task automatic scan_all();
      for (int y = 0; y < ROWS; y++)
         for (int x = 0; x < COLS; x++)
            rd(1'b0, 8'(x), 8'(y));
   endtask

   // Monitor: pops the expectations that fall due in this cycle.
   initial begin
      forever begin
         @(negedge clk);
         #4;
         while (pq.size() > 0 && pq[0].due <= cyc) begin
            pe_m = pq.pop_front();
            if (pe_m.due == cyc && pe_m.chk) chk("pix_out", 32'(pix_out), 32'(pe_m.exp));
         end
         if (cq.size() > 0) begin
            ce_m = cq.pop_front();
            chk("wr0_ready", 32'(wr0_ready), 32'(ce_m.r0));
            chk("wr1_ready", 32'(wr1_ready), 32'(ce_m.r1));
            chk("clear_busy", 32'(clear_busy), 32'(ce_m.busy));
         end
      end
   end

   initial begin
      bit g0;
      int fill_i;
      int budget;
      reset = 1'b1; blank = 1'b1; char_x = 0; char_y = 0; ascii_char = '0;
      wr0_valid = 0; wr0_x = 0; wr0_y = 0; wr0_code = 0;
      wr1_valid = 0; wr1_x = 0; wr1_y = 0; wr1_code = 0;
      clear_req = 0;
      for (int i = 0; i < CELLS; i++) m_known[i] = 1'b0;

      // Held in reset: no grants, busy, dark pixel even with requests pending.
      repeat (3) begin
         @(negedge clk);
         wr0_valid = 1'b1; wr1_valid = 1'b1;
         #1;
         chk("reset_rdy0", 32'(wr0_ready), 32'd0);
         chk("reset_rdy1", 32'(wr1_ready), 32'd0);
         chk("reset_busy", 32'(clear_busy), 32'd1);
         chk("reset_pix", 32'(pix_out), 32'd0);
      end
      @(posedge clk);
      #1 reset = 1'b0;
      model_reset();

      // Power-up sweep with requesters hammering, then a clean full-screen read.
      repeat (CELLS) rnd_step(1'b1, 1'b0);
      repeat (20) rnd_step(1'b0, 1'b0);
      scan_all();

      // Out-of-range writes from wr1 handshake but leave the screen alone.
      step(0, 0, 1, 0, 0, 0, 0, 1, 106, 0, "Z", 0, 0, g0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 0, 60, "Z", 0, 0, g0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 255, 255, "Z", 0, 0, g0);
      rd(0, 0, 1); rd(0, 0, 0); rd(0, 105, 59); rd(0, 0, 59);

      // Single write of 'A'; same-cycle read returns the old space.
      step(0, 2, 3, 1, 2, 3, "A", 0, 0, 0, 0, 0, 0, g0);
      rd(0, 2, 3); rd(0, 3, 2); rd(0, 1, 3); rd(0, 2, 4); rd(0, 2, 3);

      // Reset the tie history via a wr1-only transfer, then contend for 6 cycles.
      step(0, 0, 0, 0, 0, 0, 0, 1, 200, 0, 0, 0, 0, g0);
      for (int i = 0; i < 6; i++)
         step(0, 8'(i), 0, 1, 8'(10 + i), 5, 8'($urandom), 1, 8'(20 + i), 6, 8'($urandom), 0, 0, g0);
      for (int i = 0; i < 6; i++)
         step(0, 8'(10 + i), 5, 1, 8'(30 + i), 7, 8'($urandom), 0, 0, 0, 0, 0, 0, g0);

      // Fill every cell via wr0 while wr1 occasionally contends.
      fill_i = 0;
      budget = 0;
      while (fill_i < CELLS && budget < 3 * CELLS) begin
         step($urandom_range(0, 7) == 0, 8'($urandom_range(0, 111)), 8'($urandom_range(0, 63)),
              1, 8'(fill_i % COLS), 8'(fill_i / COLS), 8'($urandom),
              $urandom_range(0, 3) == 0, 8'($urandom_range(0, 107)), 8'($urandom_range(0, 61)), 8'($urandom),
              0, 0, g0);
         if (g0) fill_i++;
         budget++;
      end
      chk("fill_done", 32'(fill_i), 32'(CELLS));
      repeat (50) rnd_step(1'b0, 1'b0);

      // Clear alongside a wr0 transfer; a second request mid-sweep is ignored.
      step(0, 5, 5, 1, 5, 5, "Q", 0, 0, 0, 0, 1, 0, g0);
      repeat (999) rnd_step(1'b1, 1'b0);
      step(0, 5, 5, 1, 6, 6, "Q", 1, 7, 7, "R", 1, 0, g0);
      repeat (CELLS - 1000) rnd_step(1'b1, 1'b0);
      repeat (10) rnd_step(1'b0, 1'b0);
      scan_all();

      // Reset mid-handshake, then again mid-sweep; the sweep restarts from 0.
      repeat (3) rnd_step(1'b0, 1'b1);
      step(1, 0, 0, 1, 7, 7, "B", 1, 8, 8, "C", 0, 1, g0);
      repeat (100) rnd_step(1'b1, 1'b1);
      step(1, 0, 0, 1, 7, 7, "B", 0, 0, 0, 0, 0, 1, g0);
      repeat (CELLS + 10) rnd_step(1'b0, 1'b0);

      // Blanking and off-screen columns force a dark pixel over a lit cell.
      step(0, 0, 0, 1, 0, 0, "A", 0, 0, 0, 0, 0, 0, g0);
      rd(1, 0, 0); rd(0, 106, 0); rd(0, 200, 3); rd(0, 0, 60); rd(0, 0, 0);
      repeat (4) rd(1, 0, 0);
      repeat (2) @(negedge clk);
      #6;
      chk("scoreboard_drained", 32'(pq.size() + cq.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
